// File: rtl/apbspi_shift_engine.sv
// SPI master shift engine: pops frames from a FWFT TX FIFO, shifts them out
// MSB-first on mosi while sampling miso, and pushes each received frame to RX.
module apbspi_shift_engine #(
    parameter int width     = 8,
    parameter int div_width = 8
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 enable,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic [div_width-1:0] clk_div,
    input  logic                 tx_empty,
    input  logic [width-1:0]     tx_data,
    output logic                 tx_pop,
    input  logic                 rx_full,
    output logic [width-1:0]     rx_data,
    output logic                 rx_push,
    output logic                 sclk,
    output logic                 mosi,
    input  logic                 miso,
    output logic                 cs_n,
    output logic                 busy
);

    localparam int EW = $clog2(2 * width + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q;
    logic [div_width-1:0] div_q;
    logic [div_width-1:0] hcnt_q;
    logic [EW-1:0]        edge_q;
    logic                 cpol_q;
    logic                 cpha_q;
    logic [width-1:0]     tx_sh_q;
    logic [width-1:0]     rx_sh_q;
    logic [width-1:0]     rx_data_q;
    logic                 sclk_q;
    logic                 mosi_q;
    logic                 cs_n_q;
    logic                 tx_pop_q;
    logic                 rx_push_q;
    logic                 busy_q;

    logic                 start;
    logic [EW-1:0]        edge_d;
    logic                 leading;
    logic                 last_edge;
    logic                 sample_now;
    logic                 drive_now;
    logic [width-1:0]     rx_sh_d;

    assign start     = enable & ~tx_empty & ~rx_full;
    assign edge_d    = edge_q + EW'(1);
    assign leading   = edge_d[0];
    assign last_edge = (edge_d == EW'(2 * width));
    // Mode 0 samples on leading edges and shifts on trailing ones; mode 1 is the mirror.
    // The final trailing edge in mode 0 has no further bit to present.
    assign sample_now = cpha_q ? ~leading : leading;
    assign drive_now  = cpha_q ? leading : (~leading & ~last_edge);
    assign rx_sh_d    = {rx_sh_q[width-2:0], miso};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            hcnt_q    <= '0;
            edge_q    <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            tx_pop_q  <= 1'b0;
            rx_push_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            tx_pop_q  <= 1'b0;
            rx_push_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sclk_q <= cpol;
                    mosi_q <= 1'b0;
                    cs_n_q <= 1'b1;
                    if (start) begin
                        state_q  <= LOAD;
                        tx_pop_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                LOAD: begin
                    // Mode 0 presents the MSB now, so the shifter starts one bit ahead.
                    tx_sh_q <= cpha ? tx_data : {tx_data[width-2:0], 1'b0};
                    if (!cpha) begin
                        mosi_q <= tx_data[width-1];
                    end
                    cs_n_q  <= 1'b0;
                    cpol_q  <= cpol;
                    cpha_q  <= cpha;
                    div_q   <= clk_div;
                    hcnt_q  <= clk_div;
                    edge_q  <= '0;
                    sclk_q  <= cpol;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    if (hcnt_q == '0) begin
                        hcnt_q <= div_q;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_d;
                        if (sample_now) begin
                            rx_sh_q <= rx_sh_d;
                        end
                        if (drive_now) begin
                            mosi_q  <= tx_sh_q[width-1];
                            tx_sh_q <= {tx_sh_q[width-2:0], 1'b0};
                        end
                        if (last_edge) begin
                            state_q   <= DONE;
                            rx_push_q <= 1'b1;
                            rx_data_q <= sample_now ? rx_sh_d : rx_sh_q;
                        end
                    end else begin
                        hcnt_q <= hcnt_q - div_width'(1);
                    end
                end
                DONE: begin
                    if (hcnt_q == '0) begin
                        if (start) begin
                            state_q  <= LOAD;
                            tx_pop_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            mosi_q  <= 1'b0;
                            cs_n_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        hcnt_q <= hcnt_q - div_width'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Idle clock level follows cpol live so a polarity change is visible before the frame.
    assign sclk    = (state_q == IDLE) ? cpol : sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;
    assign tx_pop  = tx_pop_q;
    assign rx_push = rx_push_q;
    assign rx_data = rx_data_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_apbspi_shift_engine.sv
// Randomised bench for apbspi_shift_engine: a frame-timeline model predicts
// every output per cycle; directed scenarios pin the model with literal values.
module tb_apbspi_shift_engine;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         nrst = 1'b1;
    logic         enable = 1'b0;
    logic         cpol = 1'b0;
    logic         cpha = 1'b0;
    logic [7:0]   clk_div = 8'd0;
    logic         tx_empty = 1'b1;
    logic [W-1:0] tx_data = '0;
    logic         tx_pop;
    logic         rx_full = 1'b0;
    logic [W-1:0] rx_data;
    logic         rx_push;
    logic         sclk;
    logic         mosi;
    logic         miso;
    logic         cs_n;
    logic         busy;

    logic         loop_mode = 1'b1;
    logic         miso_drv = 1'b0;
    bit           pat_ones = 1'b0;

    assign miso = loop_mode ? mosi : miso_drv;

    apbspi_shift_engine #(.width(W), .div_width(8)) dut (
        .clk(clk), .nrst(nrst), .enable(enable), .cpol(cpol), .cpha(cpha),
        .clk_div(clk_div), .tx_empty(tx_empty), .tx_data(tx_data), .tx_pop(tx_pop),
        .rx_full(rx_full), .rx_data(rx_data), .rx_push(rx_push), .sclk(sclk),
        .mosi(mosi), .miso(miso), .cs_n(cs_n), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    logic [W-1:0] txq[$];
    logic [W-1:0] rxq[$];

    // Frame timeline model: k=0 load, 1..S shifting, S+1..S+D done.
    bit           m_active = 1'b0;
    bit           m_b2b = 1'b0;
    int           m_k = 0;
    int           m_D = 1;
    bit           m_cpol = 1'b0;
    bit           m_cpha = 1'b0;
    logic [W-1:0] m_pat = '0;
    logic [W-1:0] m_rx = '0;

    bit           pop_seen = 1'b0;
    int           pops, pushes, cs_rises, sclk_edges, first_edge_cyc, last_edge_cyc;
    int           min_gap, max_gap, pop_cyc, push_cyc;
    logic [W-1:0] mosi_seq;
    logic         prev_sclk = 1'b0;
    logic         prev_cs = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic sync_fifo();
        tx_empty = (txq.size() == 0);
        tx_data  = tx_empty ? '0 : txq[0];
    endtask

    task automatic push_tx(input logic [W-1:0] v);
        txq.push_back(v);
        sync_fifo();
    endtask

    task automatic clear_stats();
        pops = 0; pushes = 0; cs_rises = 0; sclk_edges = 0;
        first_edge_cyc = -1; last_edge_cyc = -1; min_gap = 1000; max_gap = 0;
        pop_cyc = -1; push_cyc = -1; mosi_seq = '0;
        rxq.delete();
    endtask

    function automatic int shift_len();
        return 2 * W * m_D;
    endfunction

    function automatic int edges_done();
        if (m_active && m_k >= 1 && m_k <= shift_len()) return (m_k - 1) / m_D;
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_k = 0; m_rx = '0; m_b2b = 1'b0;
    endtask

    task automatic model_step();
        bit start;
        start = enable && !tx_empty && !rx_full;
        if (!nrst) begin
            model_reset();
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1; m_k = 0; m_b2b = 1'b0;
            end
        end else if (m_k == 0) begin
            m_cpol = cpol; m_cpha = cpha; m_D = int'(clk_div) + 1;
            m_pat  = loop_mode ? tx_data : (pat_ones ? {W{1'b1}} : W'($urandom));
            m_k    = 1;
        end else if (m_k == shift_len() + m_D) begin
            if (start) begin
                m_k = 0; m_b2b = 1'b1;
            end else begin
                m_active = 1'b0;
            end
        end else begin
            m_k++;
            if (m_k == shift_len() + 1) m_rx = m_pat;
        end
    endtask

    task automatic drive_miso();
        int e;
        int idx;
        e = edges_done();
        miso_drv = 1'b0;
        if (e >= 0) begin
            idx = m_cpha ? ((e > 0) ? (e - 1) / 2 : 0) : e / 2;
            miso_drv = m_pat[W-1-idx];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        if (pop_seen) begin
            if (txq.size() > 0) void'(txq.pop_front());
            pop_seen = 1'b0;
        end
        sync_fifo();
        drive_miso();
    endtask

    task automatic wait_settle();
        int n;
        n = 0;
        while ((m_active || (enable && txq.size() > 0 && !rx_full)) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            n_chk++; n_fail++;
            $display("FAIL settle_timeout: engine still active after %0d cycles, required idle", n);
        end
        tick();
    endtask

    task automatic wait_edge(input int target);
        int n;
        n = 0;
        while (edges_done() < target && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            n_chk++; n_fail++;
            $display("FAIL edge_timeout: edge %0d not reached, required within 3000 cycles", target);
        end
    endtask

    // Per-cycle monitor and comparison against the model.
    always @(negedge clk) begin
        int e;
        int idx;
        if (nrst && chk_en) begin
            if (tx_pop) begin
                pop_seen = 1'b1; pops++; pop_cyc = cyc;
            end
            if (rx_push) begin
                rxq.push_back(rx_data); pushes++; push_cyc = cyc;
                $display("rx frame %02h at cycle %0d", rx_data, cyc);
            end
            if (cs_n && !prev_cs) cs_rises++;
            if (busy && sclk != prev_sclk) begin
                sclk_edges++;
                if (first_edge_cyc < 0) first_edge_cyc = cyc;
                else begin
                    if (cyc - last_edge_cyc < min_gap) min_gap = cyc - last_edge_cyc;
                    if (cyc - last_edge_cyc > max_gap) max_gap = cyc - last_edge_cyc;
                end
                last_edge_cyc = cyc;
                if (sclk != m_cpol && (sclk_edges % 2) == 1) mosi_seq = {mosi_seq[W-2:0], mosi};
            end
        end
        prev_sclk = sclk;
        prev_cs   = cs_n;
        if (chk_en) begin
            chk("busy", busy, m_active);
            chk("tx_pop", tx_pop, m_active && m_k == 0);
            chk("rx_push", rx_push, m_active && m_k == shift_len() + 1);
            chk("rx_data", rx_data, m_rx);
            if (!m_active) begin
                chk("cs_n_idle", cs_n, 1);
                chk("sclk_idle", sclk, cpol);
                chk("mosi_idle", mosi, 0);
            end else if (m_k == 0) begin
                chk("cs_n_load", cs_n, !m_b2b);
            end else begin
                chk("cs_n_frame", cs_n, 0);
                e = edges_done();
                if (e >= 0) begin
                    chk("sclk_shift", sclk, m_cpol ^ e[0]);
                    if (!m_cpha || e >= 1) begin
                        idx = m_cpha ? (e - 1) / 2 : e / 2;
                        chk("mosi_shift", mosi, m_pat_src(idx));
                    end
                end else begin
                    chk("sclk_done", sclk, m_cpol);
                end
            end
        end
    end

    // Transmitted word of the current frame, latched alongside the model parameters.
    logic [W-1:0] m_data = '0;
    always @(posedge clk) if (m_active && m_k == 0) m_data <= tx_data;
    function automatic logic m_pat_src(input int idx);
        return m_data[W-1-idx];
    endfunction

    initial begin
        clear_stats();
        #2 nrst = 1'b0;
        chk_en = 1'b1;
        model_reset();
        repeat (3) tick();
        nrst = 1'b1;
        tick();

        // Scenario 1: mode 0, div 1, loopback of 0xA5.
        clear_stats();
        cpol = 0; cpha = 0; clk_div = 8'd1; loop_mode = 1; enable = 1;
        push_tx(8'hA5);
        begin
            int enq;
            enq = cyc;
            wait_settle();
            chk("s1_pops", pops, 1);
            chk("s1_edges", sclk_edges, 16);
            chk("s1_latency", first_edge_cyc - enq, 4);
            chk("s1_gap_min", min_gap, 2);
            chk("s1_gap_max", max_gap, 2);
            chk("s1_mosi_seq", mosi_seq, 8'hA5);
            chk("s1_nrx", rxq.size(), 1);
            chk("s1_rx", (rxq.size() > 0) ? rxq[0] : 8'h00, 8'hA5);
            chk("s1_cs_n", cs_n, 1);
        end

        // Scenario 2: mode 3, div 3, miso tied high.
        clear_stats();
        cpol = 1; cpha = 1; clk_div = 8'd3; loop_mode = 0; pat_ones = 1;
        repeat (3) tick();
        chk("s2_sclk_idle", sclk, 1);
        push_tx(8'h3C);
        wait_settle();
        chk("s2_rx", (rxq.size() > 0) ? rxq[0] : 8'h00, 8'hFF);
        chk("s2_shift_len", push_cyc - pop_cyc - 1, 64);
        pat_ones = 0;

        // Scenario 3: back-to-back frames.
        clear_stats();
        cpol = 0; cpha = 0; clk_div = 8'd0; loop_mode = 1;
        push_tx(8'h01); push_tx(8'h02); push_tx(8'h03);
        wait_settle();
        chk("s3_pops", pops, 3);
        chk("s3_pushes", pushes, 3);
        chk("s3_cs_rises", cs_rises, 1);
        for (int i = 0; i < 3; i++) chk("s3_order", (rxq.size() > i) ? rxq[i] : 8'h00, i + 1);

        // Scenario 4: RX full gating.
        clear_stats();
        rx_full = 1;
        push_tx(8'h55);
        repeat (6) tick();
        chk("s4_busy", busy, 0);
        chk("s4_pops", pops, 0);
        rx_full = 0;
        tick();
        chk("s4_load", tx_pop, 1);
        wait_settle();
        chk("s4_rx", (rxq.size() > 0) ? rxq[0] : 8'h00, 8'h55);

        // Scenario 5: enable dropped after edge 5.
        clear_stats();
        clk_div = 8'd1;
        push_tx(8'hC3); push_tx(8'h5A);
        wait_edge(5);
        enable = 0;
        wait_settle();
        chk("s5_pushes", pushes, 1);
        chk("s5_txq_left", txq.size(), 1);
        chk("s5_busy", busy, 0);
        enable = 1;
        wait_settle();

        // Scenario 6: asynchronous reset at edge 9.
        clear_stats();
        cpol = 1;
        push_tx(8'h96); push_tx(8'h69);
        wait_edge(9);
        #2 nrst = 1'b0;
        model_reset();
        #1;
        chk("s6_cs_n", cs_n, 1);
        chk("s6_sclk", sclk, 1);
        chk("s6_mosi", mosi, 0);
        chk("s6_busy", busy, 0);
        tick();
        nrst = 1'b1;
        wait_settle();
        chk("s6_pushes", pushes, 1);
        chk("s6_rx", (rxq.size() > 0) ? rxq[0] : 8'h00, 8'h69);

        // Randomised frames with mid-frame control changes.
        for (int it = 0; it < 40; it++) begin
            loop_mode = 1'($urandom_range(1));
            pat_ones  = ($urandom_range(3) == 0);
            cpol      = 1'($urandom_range(1));
            cpha      = 1'($urandom_range(1));
            clk_div   = 8'($urandom_range(3));
            enable    = 1;
            for (int j = 0; j < 1 + $urandom_range(2); j++) push_tx(W'($urandom));
            for (int j = 0; j < 20 + $urandom_range(200); j++) begin
                tick();
                if ($urandom_range(15) == 0) cpol = 1'($urandom_range(1));
                if ($urandom_range(15) == 0) cpha = 1'($urandom_range(1));
                if ($urandom_range(15) == 0) clk_div = 8'($urandom_range(3));
                enable  = ($urandom_range(7) != 0);
                rx_full = ($urandom_range(9) == 0);
            end
            enable = 1; rx_full = 0;
            wait_settle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
